// File: rtl/chad_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// chad_muldiv_pkg
// Shared constants for the chad multiply/divide coprocessor:
//   - command select codes decoded from sel[2:0]
//   - read-select (rsel) encoding for the cop output mux
//   - bit positions inside the STAT read word
//   - IDLE/RUN state encoding of the iteration FSM
// -----------------------------------------------------------------------------
package chad_muldiv_pkg;

    // Command select codes (sel[2:0]); 5..7 are reserved.
    localparam logic [2:0] SEL_LO   = 3'd0;
    localparam logic [2:0] SEL_HI   = 3'd1;
    localparam logic [2:0] SEL_STAT = 3'd2;
    localparam logic [2:0] SEL_MUL  = 3'd3;
    localparam logic [2:0] SEL_DIV  = 3'd4;

    // What the cop output currently shows.
    typedef enum logic [1:0] {
        RSEL_LO   = 2'd0,
        RSEL_HI   = 2'd1,
        RSEL_STAT = 2'd2
    } rsel_t;

    // Bit positions inside the STAT word; all higher bits read 0.
    localparam int STAT_BUSY = 0;
    localparam int STAT_OVF  = 1;
    localparam int STAT_DZ   = 2;
    localparam int STAT_OP   = 3;

    // Iteration FSM.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : chad_muldiv_pkg

// File: rtl/chad_muldiv_if.sv
// -----------------------------------------------------------------------------
// chad_muldiv_if
// Coprocessor port between the chad core (master) and chad_muldiv (slave).
//   hold   core hold; no command is accepted while high
//   copgo  command strobe
//   sel    command select (insn[10:0]); only sel[2:0] is decoded
//   copa   operand A (core T)
//   copb   operand B (core N)
//   copc   operand C (core W); reserved
//   cop    read data returned to the core
//   busy   operation in progress
// -----------------------------------------------------------------------------
interface chad_muldiv_if #(
    parameter int WIDTH = 18
) ();

    logic             hold;
    logic             copgo;
    logic [10:0]      sel;
    logic [WIDTH-1:0] copa;
    logic [WIDTH-1:0] copb;
    logic [WIDTH-1:0] copc;
    logic [WIDTH-1:0] cop;
    logic             busy;

    // Core side: issues commands, reads results.
    modport master (
        output hold, copgo, sel, copa, copb, copc,
        input  cop, busy
    );

    // Coprocessor side.
    modport slave (
        input  hold, copgo, sel, copa, copb, copc,
        output cop, busy
    );

endinterface : chad_muldiv_if

// File: rtl/chad_muldiv_step.sv
// -----------------------------------------------------------------------------
// chad_muldiv_step
// One combinational iteration of the multiply/divide engine.
//   i_op     0 = shift-add multiply step, 1 = restoring divide step
//   i_hi     current high word (partial product / partial remainder)
//   i_lo     current low word (multiplier bits / dividend-quotient bits)
//   i_mcand  multiplicand or divisor
//   o_hi     next high word
//   o_lo     next low word
// Build option: CHAD_MULDIV_DIV_EN builds the divide path; without it only
// the multiply step exists and i_op is ignored.
// -----------------------------------------------------------------------------
module chad_muldiv_step #(
    parameter int WIDTH = 18
) (
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    // Multiply: add multiplicand when the current multiplier bit is set, keeping
    // the carry, then shift the whole {carry,hi,lo} right by one.
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_mcand} : '0);

`ifdef CHAD_MULDIV_DIV_EN
    // Divide: bring the next dividend bit into the partial remainder and try
    // to subtract the divisor. While the divisor is non-zero the remainder stays
    // below it, so the difference fits WIDTH+1 bits and bit WIDTH is its sign.
    // With a zero divisor the remainder never reaches bit WIDTH either, so every
    // step "succeeds": quotient becomes all ones and hi collects the dividend.
    logic [WIDTH:0] w_rem;
    logic [WIDTH:0] w_diff;
    assign w_rem  = {i_hi, i_lo[WIDTH-1]};
    assign w_diff = w_rem - {1'b0, i_mcand};

    always_comb begin
        o_hi = w_sum[WIDTH:1];
        o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        if (i_op) begin
            if (!w_diff[WIDTH]) begin
                o_hi = w_diff[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_rem[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end
    end
`else
    logic w_unused_op;
    assign w_unused_op = i_op;

    assign o_hi = w_sum[WIDTH:1];
    assign o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
`endif

endmodule : chad_muldiv_step

// File: rtl/chad_muldiv.sv
// -----------------------------------------------------------------------------
// chad_muldiv
// Iterative multiply/divide coprocessor on the chad core's coprocessor port.
// One result bit per clock; busy is high for exactly WIDTH cycles after the
// edge that accepts a start command, results are valid once busy drops.
// Ports:
//   clk    system clock, all state on posedge
//   reset  asynchronous, active-high reset
//   bus    chad_muldiv_if.slave: hold, copgo, sel, copa, copb, copc in;
//          cop, busy out
// Build option: CHAD_MULDIV_DIV_EN enables select 4 (unsigned restoring
// divide). Without it select 4 is reserved and STAT dz/op read 0.
// -----------------------------------------------------------------------------
module chad_muldiv
    import chad_muldiv_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic          clk,
    input  logic          reset,
    chad_muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_mcand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    rsel_t            r_rsel;

    logic             w_op;
    logic             w_dz;
    logic             w_busy;
    logic             w_accept;
    logic [2:0]       w_sel;
    logic             w_start_mul;
    logic             w_start_div;
    logic             w_start;
    logic             w_launch;
    logic             w_last;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH-1:0] w_stat;

    // copc and the undecoded select bits are reserved.
    logic w_unused;
    assign w_unused = ^{bus.copc, bus.sel[10:3]};

    // ---------------- command decode ----------------
    assign w_accept    = bus.copgo & ~bus.hold;
    assign w_sel       = bus.sel[2:0];
    assign w_busy      = (r_state == ST_RUN);
    assign w_start_mul = w_accept & (w_sel == SEL_MUL);
`ifdef CHAD_MULDIV_DIV_EN
    assign w_start_div = w_accept & (w_sel == SEL_DIV);
`else
    assign w_start_div = 1'b0;
`endif
    assign w_start  = w_start_mul | w_start_div;
    // A start only launches from IDLE; while busy it just flags overflow.
    assign w_launch = w_start & ~w_busy;
    assign w_last   = w_busy & (r_cnt == CNT_W'(1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_launch) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)   w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    chad_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_op    (w_op),
        .i_hi    (r_hi),
        .i_lo    (r_lo),
        .i_mcand (r_mcand),
        .o_hi    (w_step_hi),
        .o_lo    (w_step_lo)
    );

    // Iteration ignores hold: once launched it always runs WIDTH steps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo    <= '0;
            r_hi    <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (w_launch) begin
            r_lo    <= bus.copa;
            r_hi    <= '0;
            r_mcand <= bus.copb;
            r_cnt   <= CNT_W'(WIDTH);
        end else if (w_busy) begin
            r_lo    <= w_step_lo;
            r_hi    <= w_step_hi;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

`ifdef CHAD_MULDIV_DIV_EN
    logic r_op;
    logic r_dz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= 1'b0;
            r_dz <= 1'b0;
        end else if (w_launch) begin
            r_op <= w_start_div;
            r_dz <= w_start_div & (bus.copb == '0);
        end
    end

    assign w_op = r_op;
    assign w_dz = r_dz;
`else
    assign w_op = 1'b0;
    assign w_dz = 1'b0;
`endif

    // ---------------- read select and overflow flag ----------------
    // Non-start selects are honoured even while busy. A start that collides
    // with a running operation is dropped and only leaves the sticky ovf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsel <= RSEL_LO;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            case (w_sel)
                SEL_LO: r_rsel <= RSEL_LO;
                SEL_HI: r_rsel <= RSEL_HI;
                SEL_STAT: begin
                    r_rsel <= RSEL_STAT;
                    r_ovf  <= 1'b0;
                end
                default: begin
                    if (w_start) begin
                        if (w_busy) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_rsel <= RSEL_LO;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- read mux ----------------
    // Built only from registers, so cop follows lo/hi live during a run.
    always_comb begin
        w_stat            = '0;
        w_stat[STAT_BUSY] = w_busy;
        w_stat[STAT_OVF]  = r_ovf;
        w_stat[STAT_DZ]   = w_dz;
        w_stat[STAT_OP]   = w_op;
    end

    always_comb begin
        bus.cop = '0;
        case (r_rsel)
            RSEL_LO:   bus.cop = r_lo;
            RSEL_HI:   bus.cop = r_hi;
            RSEL_STAT: bus.cop = w_stat;
            default:   bus.cop = '0;
        endcase
    end

    assign bus.busy = w_busy;

endmodule : chad_muldiv

// File: tb/tb_chad_muldiv.sv
// -----------------------------------------------------------------------------
// tb_chad_muldiv
// Self-checking bench for chad_muldiv (WIDTH=18). Each start pushes the
// model's expected {lo, hi, STAT} onto a scoreboard; when busy drops the entry
// is popped and compared against LO/HI/STAT reads through the cop port.
// Divide tests run when CHAD_MULDIV_DIV_EN is defined; otherwise select 4 is
// checked to have no effect.
// -----------------------------------------------------------------------------
module tb_chad_muldiv;
    import chad_muldiv_pkg::*;

    localparam int W = 18;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [3:0]   stat;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset;
    int     n_checks = 0;
    int     n_errors = 0;
    exp_t   sb[$];
    string  sb_tag[$];
    logic [W-1:0] last_lo;
    logic [W-1:0] last_hi;

    chad_muldiv_if #(.WIDTH(W)) bus ();

    chad_muldiv #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Present one command for one clock; returns 1 time unit after that edge.
    task automatic cmd(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.copgo = 1'b1;
        bus.sel   = {8'h00, s};
        bus.copa  = a;
        bus.copb  = b;
        bus.copc  = a ^ b;
        @(posedge clk);
        #1;
        bus.copgo = 1'b0;
    endtask

    task automatic start_mul(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [63:0] p;
        exp_t e;
        p      = 64'(a) * 64'(b);
        e.lo   = p[W-1:0];
        e.hi   = p[2*W-1:W];
        e.stat = 4'b0000;
        sb.push_back(e);
        sb_tag.push_back(tag);
        cmd(SEL_MUL, a, b);
    endtask

    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        exp_t e;
        if (b == '0) begin
            e.lo   = '1;
            e.hi   = a;
            e.stat = 4'b1100;
        end else begin
            e.lo   = a / b;
            e.hi   = a % b;
            e.stat = 4'b1000;
        end
        sb.push_back(e);
        sb_tag.push_back(tag);
        cmd(SEL_DIV, a, b);
    endtask

    // Counts cycles with busy high, bounded so a stuck DUT still terminates.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_op(input bit chk_lat);
        int    n;
        exp_t  e;
        string t;
        wait_done(n);
        bus.hold = 1'b0;
        check("done_busy", W'(bus.busy), '0);
        if (chk_lat) check("latency", W'(n), W'(W));
        check("sb_size", W'(sb.size()), W'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        t = sb_tag.pop_front();
        cmd(SEL_LO, '0, '0);
        check({t, "_lo"}, bus.cop, e.lo);
        cmd(SEL_HI, '0, '0);
        check({t, "_hi"}, bus.cop, e.hi);
        cmd(SEL_STAT, '0, '0);
        check({t, "_stat"}, bus.cop, W'(e.stat));
        last_lo = e.lo;
        last_hi = e.hi;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        bus.hold  = 1'b0;
        bus.copgo = 1'b0;
        bus.sel   = '0;
        bus.copa  = '0;
        bus.copb  = '0;
        bus.copc  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", W'(bus.busy), '0);
        check("rst_cop", bus.cop, '0);
        @(negedge clk);
        reset = 1'b0;

        // Full-scale multiply and a few edge/random operand pairs.
        start_mul(18'h3FFFF, 18'h3FFFF, "mul_max");
        finish_op(1);
        check("mul_max_hi_const", last_hi, 18'h3FFFE);
        start_mul(18'h00000, 18'h2AAAA, "mul_zero");
        finish_op(1);
        start_mul(18'h00001, 18'h3FFFF, "mul_one");
        finish_op(1);
        for (int i = 0; i < 3; i++) begin
            start_mul(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), "mul_rnd");
            finish_op(1);
        end

        // Colliding start: ignored, sets sticky ovf; STAT select clears it.
        start_mul(18'h00123, 18'h00456, "mul_ovf");
        cmd(SEL_STAT, '0, '0);
        check("stat_run", bus.cop, 18'h00001);
        @(posedge clk);
        #1;
        cmd(SEL_MUL, 18'h3FFFF, 18'h3FFFF);
        check("stat_ovf", bus.cop, 18'h00003);
        cmd(SEL_STAT, '0, '0);
        check("stat_ovf_clr", bus.cop, 18'h00001);
        finish_op(0);

        // hold blocks command acceptance.
        cmd(SEL_HI, '0, '0);
        bus.hold = 1'b1;
        cmd(SEL_MUL, 18'h00005, 18'h00006);
        check("hold_busy", W'(bus.busy), '0);
        check("hold_cop_hi", bus.cop, last_hi);
        bus.hold = 1'b0;
        cmd(SEL_LO, '0, '0);
        check("hold_lo", bus.cop, last_lo);

        // hold asserted mid-run does not stretch the operation.
        start_mul(18'h2F0F0, 18'h1ABCD, "mul_hold");
        bus.hold = 1'b1;
        finish_op(1);

        // Reset at cycle 5 of a run aborts it at once.
        start_mul(18'h3FFFF, 18'h12345, "mul_abort");
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", W'(bus.busy), '0);
        check("abort_cop", bus.cop, '0);
        void'(sb.pop_back());
        void'(sb_tag.pop_back());
        @(negedge clk);
        reset = 1'b0;
        cmd(SEL_HI, '0, '0);
        check("abort_hi", bus.cop, '0);
        start_mul(18'h0BEEF, 18'h00FAD, "mul_after_rst");
        finish_op(1);

`ifdef CHAD_MULDIV_DIV_EN
        start_div(18'd100, 18'd7, "div_100_7");
        finish_op(1);
        start_div(18'h12345, 18'h00000, "div_zero");
        finish_op(1);
        start_div(18'h3FFFF, 18'h00001, "div_one");
        finish_op(1);
        start_div(18'h00005, 18'h3FFFF, "div_small");
        finish_op(1);
        for (int i = 0; i < 3; i++) begin
            start_div(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(1, (1 << W) - 1)), "div_rnd");
            finish_op(1);
        end
        start_mul(18'h00077, 18'h00099, "mul_after_div");
        finish_op(1);
`else
        cmd(SEL_LO, '0, '0);
        cmd(SEL_DIV, 18'h12345, 18'h00007);
        check("nodiv_busy", W'(bus.busy), '0);
        check("nodiv_lo", bus.cop, last_lo);
        cmd(SEL_STAT, '0, '0);
        check("nodiv_stat", bus.cop, '0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_chad_muldiv
